sample_data_in_port: RTL and testbench
======================================

# sample_data_in_port

Avalon-MM slave input port with edge capture and interrupt, the read-side counterpart of the Nios II–controlled output port that drives the sample-buffer read address. It brings an asynchronous parallel data bus (sample data returned from the buffer, plus status strobes) into the clock domain through a synchronizer. It exposes the bus as a memory-mapped register, latches selected edges per bit, and raises a level interrupt to the Nios II when an unmasked edge bit is set.

## Interface
Parameters:
- WIDTH, 16, number of input bits (1..32)
- EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any
- SYNC_STAGES, 2, synchronizer depth before the value register (2 or 3)

Ports:
- clk  in  1  single system clock
- reset_n  in  1  reset; asynchronous assert, active-low
- address  in  2  register word select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous input bus
- readdata  out  32  read data, zero-extended from WIDTH
- irq  out  1  level interrupt, active-high

## Operation
- Synchronizer: SYNC_STAGES flops on in_port. The last stage is the data register `sync`. A further flop `prev` holds the previous `sync`.
- Edge detect per bit:
  - rising: sync & ~prev
  - falling: ~sync & prev
  - any: sync ^ prev
- Register map (readdata combinational from address, zero read latency, read has no side effects):
  - 0 DATA, RO: `sync`; writes ignored
  - 1 RESERVED: reads 0; writes ignored
  - 2 IRQMASK, RW: WIDTH bits; write when chipselect & ~write_n & address==2
  - 3 EDGECAP, R/W1C: WIDTH sticky bits; writing 1 to a bit clears it, writing 0 leaves it
- Unused upper readdata bits [31:WIDTH] are always 0. writedata bits above WIDTH are ignored.
- EDGECAP bit n sets on any clock where edge n is detected.
- If a set and a W1C clear of the same bit occur in one cycle, set wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), combinational from registers, glitch-free.
- Reset values: all synchronizer flops, `prev`, IRQMASK and EDGECAP are 0. Therefore irq=0 and readdata=0 for every address during and after reset until inputs propagate.
- The first cycles after reset release can show a spurious rising/any edge if in_port is high. This is accepted; software clears EDGECAP after enabling.

## Timing
- Clock edges are numbered E0, E1, … after in_port changes, setup-meeting before E0.
- SYNC_STAGES=2:
  - DATA read reflects the new value after E1.
  - Edge detect is true between E1 and E2.
  - EDGECAP bit is set after E2.
  - irq rises after E2 (if mask bit set).
- Each extra sync stage adds one cycle to every figure above.
- Input pulses shorter than one clock period may be missed. No guarantee is made for them.
- IRQMASK write takes effect after the writing clock edge, so irq can change the cycle after the write.
- EDGECAP clear takes effect after the writing clock edge. irq deasserts the same cycle if no other unmasked bit is set.
- Asynchronous reset mid-operation clears all state immediately; irq drops without waiting for a clock.

## Test plan
- Reset: hold reset_n=0 with in_port=0xFFFF. readdata=0 at all four addresses and irq=0. Release, wait 3 clocks; address 0 reads 0xFFFF. With EDGE_TYPE=0, EDGECAP reads 0xFFFF (startup edge).
- Capture/IRQ: write 0xFFFF to EDGECAP (clears) and 0x0001 to IRQMASK. Drive in_port bit0 0→1 before E0. DATA bit0=1 after E1, EDGECAP=0x0001 and irq=1 after E2. Write 0x0001 to address 3; irq=0 the next cycle.
- Masking: IRQMASK=0x0000, toggle bit5 rising. EDGECAP=0x0020 and irq stays 0. Write IRQMASK=0x0020; irq=1 the cycle after.
- Simultaneous clear and edge: time a W1C of bit3 on the same edge where a new bit3 edge is detected. EDGECAP bit3 remains 1 and irq remains 1.
- EDGE_TYPE variants: pulse bit7 0→1→0 with 4-cycle width. Expected EDGECAP bit7 is 1 for rising, 1 for falling, 1 for any. A clear after the rise then re-checked at the fall gives 0 for rising, 1 for falling, 1 for any.
- Bus hygiene: write 0xDEADBEEF to addresses 0 and 1, then read. Address 0 equals in_port; address 1 reads 0; IRQMASK and EDGECAP are unchanged. Write IRQMASK=0xFFFFFFFF; readback 0x0000FFFF.

Source files
------------

// File: rtl/sample_data_in_port_if.sv
// Avalon-MM slave bus for the sample-data input port.
// The master drives the address and write controls; the slave returns readdata.
interface sample_data_in_port_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/sample_data_in_port.sv
// Synchronised parallel input port with per-bit edge capture and a maskable level interrupt.
// Latency: DATA visible SYNC_STAGES-1 edges after E0, capture bit set one edge later; reads take zero cycles.
module sample_data_in_port #(
   parameter int WIDTH       = 16,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sample_data_in_port_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] clr_mask;
   logic             wr_en;
   logic             unused_wd;

   assign sync = chain[SYNC_STAGES-1];

   // Stage 0 samples the asynchronous bus; the last stage is the architectural DATA value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
         prev  <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], in_port};
         prev  <= sync;
      end
   end

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_det = sync & ~prev;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = ~sync & prev;
      end else begin : g_any
         assign edge_det = sync ^ prev;
      end
   endgenerate

   assign wr_en     = bus.chipselect & ~bus.write_n;
   assign clr_mask  = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
   assign unused_wd = ^bus.writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (wr_en && bus.address == 2'd2)
            irq_mask <= bus.writedata[WIDTH-1:0];
         // OR-ing the new edges after the clear lets a same-cycle edge win over W1C.
         edge_cap <= (edge_cap & ~clr_mask) | edge_det;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0:    bus.readdata = 32'(sync);
         2'd2:    bus.readdata = 32'(irq_mask);
         2'd3:    bus.readdata = 32'(edge_cap);
         default: bus.readdata = '0;
      endcase
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_sample_data_in_port.sv
// Directed bench: one instance per edge type sharing in_port and bus stimulus.
module tb_sample_data_in_port;
   logic        clk;
   logic        reset_n;
   logic [15:0] in_port;
   logic        irq0, irq1, irq2;
   int          checks;
   int          errors;

   sample_data_in_port_if bus0 ();
   sample_data_in_port_if bus1 ();
   sample_data_in_port_if bus2 ();

   sample_data_in_port #(.WIDTH(16), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
   sample_data_in_port #(.WIDTH(16), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
      .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));
   sample_data_in_port #(.WIDTH(16), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
      .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] d);
      bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = d;
      bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = d;
      bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = d;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      set_bus(a, 1'b1, 1'b0, d);
      tick();
      set_bus(a, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic rd(input logic [1:0] a);
      set_bus(a, 1'b1, 1'b1, 32'h0);
      #1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      in_port = 16'hFFFF;
      set_bus(2'd0, 1'b0, 1'b1, 32'h0);

      // Reset: everything reads zero while held
      tick(); tick();
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0]);
         chk("reset_rd", bus0.readdata, 32'h0);
      end
      chk("reset_irq", {31'h0, irq0}, 32'h0);

      reset_n = 1'b1;
      tick(); tick(); tick();
      rd(2'd0); chk("post_reset_data", bus0.readdata, 32'h0000FFFF);
      rd(2'd3); chk("startup_cap_rise", bus0.readdata, 32'h0000FFFF);
      chk("startup_cap_fall", bus1.readdata, 32'h0);
      chk("startup_cap_any", bus2.readdata, 32'h0000FFFF);
      chk("startup_irq", {31'h0, irq0}, 32'h0);

      // Capture and irq on bit0
      in_port = 16'h0000;
      tick(); tick(); tick(); tick();
      bus_write(2'd3, 32'h0000FFFF);
      bus_write(2'd2, 32'h00000001);
      rd(2'd3); chk("cap_cleared", bus0.readdata, 32'h0);
      in_port = 16'h0001;
      tick();
      tick();
      rd(2'd0); chk("data_after_e1", bus0.readdata, 32'h00000001);
      chk("irq_before_e2", {31'h0, irq0}, 32'h0);
      tick();
      rd(2'd3); chk("cap_after_e2", bus0.readdata, 32'h00000001);
      chk("irq_after_e2", {31'h0, irq0}, 32'h1);
      bus_write(2'd3, 32'h00000001);
      chk("irq_after_w1c", {31'h0, irq0}, 32'h0);
      rd(2'd3); chk("cap_after_w1c", bus0.readdata, 32'h0);

      // Masked bit5 edge
      bus_write(2'd2, 32'h0);
      in_port = 16'h0021;
      tick(); tick(); tick();
      rd(2'd3); chk("masked_cap", bus0.readdata, 32'h00000020);
      chk("masked_irq", {31'h0, irq0}, 32'h0);
      bus_write(2'd2, 32'h00000020);
      chk("unmask_irq", {31'h0, irq0}, 32'h1);

      // Same-edge set and W1C of bit3: set wins
      bus_write(2'd3, 32'h00000020);
      bus_write(2'd2, 32'h00000008);
      chk("pre_sim_irq", {31'h0, irq0}, 32'h0);
      in_port = 16'h0029;
      tick();
      tick();
      bus_write(2'd3, 32'h00000008);
      rd(2'd3); chk("sim_cap", bus0.readdata, 32'h00000008);
      chk("sim_irq", {31'h0, irq0}, 32'h1);

      // Bus hygiene
      bus_write(2'd0, 32'hDEADBEEF);
      bus_write(2'd1, 32'hDEADBEEF);
      rd(2'd0); chk("hyg_data", bus0.readdata, 32'h00000029);
      rd(2'd1); chk("hyg_rsvd", bus0.readdata, 32'h0);
      rd(2'd2); chk("hyg_mask", bus0.readdata, 32'h00000008);
      rd(2'd3); chk("hyg_cap", bus0.readdata, 32'h00000008);
      bus_write(2'd2, 32'hFFFFFFFF);
      rd(2'd2); chk("mask_trunc", bus0.readdata, 32'h0000FFFF);
      bus_write(2'd3, 32'h00000008);
      rd(2'd3); chk("cap_clear_bit3", bus0.readdata, 32'h0);

      // Edge-type variants: 4-cycle pulse on bit7
      tick(); tick(); tick();
      bus_write(2'd3, 32'h0000FFFF);
      rd(2'd3);
      chk("et_clr_rise", bus0.readdata, 32'h0);
      chk("et_clr_fall", bus1.readdata, 32'h0);
      chk("et_clr_any", bus2.readdata, 32'h0);
      in_port = 16'h00A9;
      tick(); tick(); tick(); tick();
      in_port = 16'h0029;
      tick(); tick(); tick(); tick();
      rd(2'd3);
      chk("pulse_rise", bus0.readdata, 32'h00000080);
      chk("pulse_fall", bus1.readdata, 32'h00000080);
      chk("pulse_any", bus2.readdata, 32'h00000080);

      bus_write(2'd3, 32'h0000FFFF);
      in_port = 16'h00A9;
      tick(); tick(); tick();
      bus_write(2'd3, 32'h00000080);
      in_port = 16'h0029;
      tick(); tick(); tick(); tick();
      rd(2'd3);
      chk("reclr_rise", bus0.readdata, 32'h0);
      chk("reclr_fall", bus1.readdata, 32'h00000080);
      chk("reclr_any", bus2.readdata, 32'h00000080);

      // Asynchronous reset drops irq without a clock edge
      chk("pre_arst_irq", {31'h0, irq1}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("arst_irq_fall", {31'h0, irq1}, 32'h0);
      chk("arst_irq_any", {31'h0, irq2}, 32'h0);
      rd(2'd2); chk("arst_mask", bus0.readdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
